// File: rtl/eth_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_sched
// Description : Round-robin scheduler that shares one eth_tx2 transmitter and
//               its 1 KiB frame BRAM between N_REQ frame sources. The granted
//               source fills the BRAM through a zero-latency write mux. Once
//               it reports fill_done, the scheduler starts eth_tx2 and waits
//               for the frame to leave. It then idles for HOLDOFF cycles
//               before arbitrating again.
// Ports       : clk, rst (async, active high)
//               req/fill_done/wr_en_i        per-source control, N_REQ bits
//               wr_addr_i/wr_data_i          per-source write buses (10b/8b each)
//               grant/sent/abort             per-source status, N_REQ bits
//               bram_wr_en/addr/data         muxed BRAM write port
//               tx_start (out), tx_busy (in) eth_tx2 handshake
// Revision    : 1.0  initial release
// ============================================================================
module eth_tx_sched #(
  parameter int N_REQ     = 2,
  parameter int FILL_TMO  = 4096,
  parameter int START_TMO = 1024,
  parameter int HOLDOFF   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     fill_done,
  input  logic [N_REQ-1:0]     wr_en_i,
  input  logic [N_REQ*10-1:0]  wr_addr_i,
  input  logic [N_REQ*8-1:0]   wr_data_i,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     sent,
  output logic [N_REQ-1:0]     abort,
  output logic                 bram_wr_en,
  output logic [9:0]           bram_wr_addr,
  output logic [7:0]           bram_wr_data,
  output logic                 tx_start,
  input  logic                 tx_busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Each timed state exits in the cycle its timer hits the last count,
  // so the state lasts exactly the configured number of cycles.
  localparam logic [12:0] c_fill_last  = 13'(FILL_TMO - 1);
  localparam logic [12:0] c_start_last = 13'(START_TMO - 1);
  localparam logic [12:0] c_hold_last  = 13'(HOLDOFF - 1);
  localparam logic [IW-1:0] c_last_idx = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_TX    = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [12:0]      r_timer;
  logic [IW-1:0]    r_rr;
  logic [IW-1:0]    r_gidx;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_sent;
  logic [N_REQ-1:0] r_abort;
  logic             r_tx_start;
  logic             r_busy_q;

  logic             w_any;
  logic [IW-1:0]    w_win;
  int               w_cand;
  logic [IW-1:0]    w_rr_next;
  logic [IW-1:0]    w_sel_idx;
  logic             w_busy_rise;
  logic             w_sent_set;
  logic             w_abort_set;
  logic             w_fill;

  logic [9:0]       w_addr [N_REQ];
  logic [7:0]       w_data [N_REQ];

  // Unpack the flat per-source write buses.
  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign w_addr[k] = wr_addr_i[10*k +: 10];
    assign w_data[k] = wr_data_i[8*k +: 8];
  end

  // Round-robin pick: first requesting source at or after the pointer.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = (int'(r_rr) + i) % N_REQ;
      if (!w_any && req[w_cand[IW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_cand[IW-1:0];
      end
    end
  end

  assign w_rr_next = (w_win == c_last_idx) ? '0 : w_win + IW'(1);
  assign w_sel_idx = (r_state == S_IDLE) ? w_win : r_gidx;

  // A start is only acknowledged by a fresh rising edge of tx_busy, so a
  // frame already on the wire when we enter START is not mistaken for ours.
  assign w_busy_rise = tx_busy & ~r_busy_q;

  always_comb begin
    w_next      = r_state;
    w_sent_set  = 1'b0;
    w_abort_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_FILL;
      end
      S_FILL: begin
        // fill_done has priority over both timeout and a dropped request.
        if (fill_done[r_gidx]) begin
          w_next = S_START;
        end else if (!req[r_gidx] || (r_timer == c_fill_last)) begin
          w_next      = S_HOLD;
          w_abort_set = 1'b1;
        end
      end
      S_START: begin
        if (w_busy_rise) begin
          w_next = S_TX;
        end else if (r_timer == c_start_last) begin
          w_next      = S_HOLD;
          w_abort_set = 1'b1;
        end
      end
      S_TX: begin
        if (!tx_busy) begin
          w_next     = S_HOLD;
          w_sent_set = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_timer == c_hold_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_rr       <= '0;
      r_gidx     <= '0;
      r_grant    <= '0;
      r_sent     <= '0;
      r_abort    <= '0;
      r_tx_start <= 1'b0;
      r_busy_q   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy_q <= tx_busy;
      // IDLE and TX are untimed; holding the timer at zero there keeps it
      // from ever wrapping.
      if ((w_next != r_state) || (r_state == S_IDLE) || (r_state == S_TX))
        r_timer <= '0;
      else
        r_timer <= r_timer + 13'd1;
      if ((r_state == S_IDLE) && w_any) begin
        r_gidx <= w_win;
        r_rr   <= w_rr_next;
      end
      r_grant    <= (w_next == S_FILL) ? (N_REQ'(1) << w_sel_idx) : '0;
      r_tx_start <= (w_next == S_START);
      r_sent     <= w_sent_set  ? (N_REQ'(1) << r_gidx) : '0;
      r_abort    <= w_abort_set ? (N_REQ'(1) << r_gidx) : '0;
    end
  end

  // Write mux is combinational so the owner sees no extra BRAM latency.
  assign w_fill       = (r_state == S_FILL);
  assign bram_wr_en   = w_fill & wr_en_i[r_gidx];
  assign bram_wr_addr = w_fill ? w_addr[r_gidx] : '0;
  assign bram_wr_data = w_fill ? w_data[r_gidx] : '0;

  assign grant    = r_grant;
  assign sent     = r_sent;
  assign abort    = r_abort;
  assign tx_start = r_tx_start;

endmodule
`default_nettype wire
